exc_req_unit: RTL and testbench

- Request side of the coprocessor-0 exception interface: decides when the CPU takes an exception and drives CP0's exception/eret/cause/pc inputs.
- Merges synchronous exceptions from the decoder (syscall, break, teq) with external interrupt lines.
- Gates requests with CP0 status, arbitrates them, tracks handler nesting through eret, and tells the datapath to suppress the current instruction.
- Sits between the control unit and cp0 in the single-cycle CPU.

---
 rtl/exc_req_unit_pkg.sv | 27 ++
 rtl/exc_req_unit_if.sv | 40 ++++
 rtl/exc_req_unit_irq_sync_edge.sv | 36 +++
 rtl/exc_req_unit.sv | 125 ++++++++++++
 tb/tb_exc_req_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_req_unit_pkg.sv
// Shared constants for the CP0 exception request unit: cause codes,
// status bit positions and the default interrupt-mask base.
// Latency: n/a (constants only). Backpressure: n/a.
package exc_pkg;

  // Cause codes written to CP0 cause.
  localparam logic [4:0] CAUSE_INT     = 5'd0;
  localparam logic [4:0] CAUSE_SYSCALL = 5'd8;
  localparam logic [4:0] CAUSE_BREAK   = 5'd9;
  localparam logic [4:0] CAUSE_TEQ     = 5'd13;

  // CP0 status bit positions.
  localparam int ST_IE         = 0;
  localparam int ST_SYSCALL_EN = 8;
  localparam int ST_BREAK_EN   = 9;
  localparam int ST_TEQ_EN     = 10;

  // status[IRQ_MASK_BASE_DEF + i] enables interrupt line i.
  localparam int IRQ_MASK_BASE_DEF = 11;

  // A sync exception decision: whether one is taken and its cause code.
  typedef struct packed {
    logic       take;
    logic [4:0] code;
  } sync_req_t;

endpackage

// File: rtl/exc_req_unit_if.sv
// Bundle between the control unit (master) and the exception request unit (slave).
// Latency: n/a (wires only). Backpressure: none, the CPU is single-cycle.
// Master drives decoder/ALU/CP0 status and IRQ lines; slave returns the CP0 controls.
interface exc_req_if #(
  parameter int N_IRQ = 4
);
  // Instruction/CPU side
  logic [31:0]      pc;
  logic             is_syscall;
  logic             is_break;
  logic             is_teq;
  logic             teq_eq;
  logic             is_eret;
  logic [31:0]      status;
  logic [N_IRQ-1:0] irq;
  logic [N_IRQ-1:0] irq_clr;

  // CP0 / datapath side
  logic             exception;
  logic             eret;
  logic [4:0]       cause;
  logic [31:0]      epc;
  logic             flush;
  logic             irq_ack;
  logic [2:0]       irq_id;
  logic [N_IRQ-1:0] pending;
  logic [1:0]       depth;
  logic             eret_err;

  modport master (
    output pc, is_syscall, is_break, is_teq, teq_eq, is_eret, status, irq, irq_clr,
    input  exception, eret, cause, epc, flush, irq_ack, irq_id, pending, depth, eret_err
  );

  modport slave (
    input  pc, is_syscall, is_break, is_teq, teq_eq, is_eret, status, irq, irq_clr,
    output exception, eret, cause, epc, flush, irq_ack, irq_id, pending, depth, eret_err
  );

endinterface

// File: rtl/exc_req_unit_irq_sync_edge.sv
// One interrupt line: 2-flop synchronizer followed by a rising-edge detector.
// Latency: irq_in rise -> rise pulse after 2 clk edges, high for one cycle.
// Backpressure: none; ports clk, rst (async active-low), irq_in (async), rise.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Flops reset to 0, so a line already high at reset release yields one pulse.
  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/exc_req_unit.sv
// Decides when the CPU takes an exception (sync or IRQ) and drives CP0 exception/eret/cause/pc.
// Latency: decision is combinational in the cycle; depth/pending update on the next clk;
// irq rise -> pending visible after 3 clk edges. Backpressure: none, single-cycle CPU.
// Ports: clk, rst (async active-low), bus (exc_req_if.slave: decoder/status/irq in, CP0 controls out).
module exc_req_unit
  import exc_pkg::*;
#(
  parameter int N_IRQ         = 4,
  parameter int IRQ_MASK_BASE = IRQ_MASK_BASE_DEF,
  parameter int MAX_DEPTH     = 3
) (
  input logic       clk,
  input logic       rst,
  exc_req_if.slave  bus
);

  localparam logic [1:0] MAX_DEPTH_W = 2'(MAX_DEPTH);

  logic [N_IRQ-1:0] irq_rise;

  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [1:0]       depth_q,   depth_d;
  logic             eret_err_q, eret_err_d;

  sync_req_t        sync_req;
  logic             irq_take;
  logic [2:0]       irq_idx;
  logic [N_IRQ-1:0] irq_taken_vec;
  logic             below_max;
  logic             exc_take;

  logic unused_status;
  assign unused_status = ^bus.status;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_irq
    irq_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .irq_in (bus.irq[g]),
      .rise   (irq_rise[g])
    );
  end

  // Exception decision.
  always_comb begin
    below_max = (depth_q < MAX_DEPTH_W);
    sync_req  = '0;

    if (bus.status[ST_IE] && below_max) begin
      if (bus.is_syscall && bus.status[ST_SYSCALL_EN]) begin
        sync_req.take = 1'b1;
        sync_req.code = CAUSE_SYSCALL;
      end else if (bus.is_break && bus.status[ST_BREAK_EN]) begin
        sync_req.take = 1'b1;
        sync_req.code = CAUSE_BREAK;
      end else if (bus.is_teq && bus.teq_eq && bus.status[ST_TEQ_EN]) begin
        sync_req.take = 1'b1;
        sync_req.code = CAUSE_TEQ;
      end
    end

    // Sync beats IRQ; eret holds IRQs off for this cycle. Downward scan
    // leaves the lowest enabled pending index as the winner.
    irq_take = 1'b0;
    irq_idx  = 3'd0;
    if (!sync_req.take && !bus.is_eret && bus.status[ST_IE] && below_max) begin
      for (int i = N_IRQ - 1; i >= 0; i--) begin
        if (pending_q[i] && bus.status[IRQ_MASK_BASE + i]) begin
          irq_take = 1'b1;
          irq_idx  = 3'(i);
        end
      end
    end

    exc_take = sync_req.take | irq_take;

    irq_taken_vec = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      irq_taken_vec[i] = irq_take && (irq_idx == 3'(i));
    end
  end

  // Next-state: clears applied first, then a fresh edge may set the bit again.
  always_comb begin
    pending_d  = (pending_q & ~bus.irq_clr & ~irq_taken_vec) | irq_rise;
    depth_d    = depth_q;
    eret_err_d = eret_err_q;

    if (exc_take) begin
      if (depth_q != MAX_DEPTH_W) begin
        depth_d = depth_q + 2'd1;
      end
    end else if (bus.is_eret) begin
      if (depth_q == 2'd0) begin
        eret_err_d = 1'b1;
      end else begin
        depth_d = depth_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      depth_q    <= 2'd0;
      eret_err_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      depth_q    <= depth_d;
      eret_err_q <= eret_err_d;
    end
  end

  assign bus.exception = exc_take;
  assign bus.eret      = bus.is_eret;
  assign bus.cause     = sync_req.take ? sync_req.code : CAUSE_INT;
  assign bus.epc       = exc_take ? bus.pc : 32'd0;
  assign bus.flush     = exc_take;
  assign bus.irq_ack   = irq_take;
  assign bus.irq_id    = irq_idx;
  assign bus.pending   = pending_q;
  assign bus.depth     = depth_q;
  assign bus.eret_err  = eret_err_q;

endmodule

// File: tb/tb_exc_req_unit.sv
module tb_exc_req_unit;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exc_req_if #(.N_IRQ(NI)) bus();

  exc_req_unit #(.N_IRQ(NI), .IRQ_MASK_BASE(11), .MAX_DEPTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit [NI-1:0] m_pend;
  int          m_depth;
  bit          m_err;
  bit [NI-1:0] m_hist [3];   // irq sampled at the last three edges, [0] newest

  // Expected combinational outputs
  bit       e_exc;
  bit [4:0] e_cause;
  bit       e_ack;
  int       e_id;

  task automatic model_reset();
    m_pend  = '0;
    m_depth = 0;
    m_err   = 1'b0;
    for (int k = 0; k < 3; k++) m_hist[k] = '0;
  endtask

  task automatic model_eval();
    bit found;
    e_exc = 0; e_cause = 0; e_ack = 0; e_id = 0; found = 0;
    if (m_depth < 3 && bus.status[0]) begin
      if (bus.is_syscall && bus.status[8]) begin
        e_exc = 1; e_cause = 8;
      end else if (bus.is_break && bus.status[9]) begin
        e_exc = 1; e_cause = 9;
      end else if (bus.is_teq && bus.teq_eq && bus.status[10]) begin
        e_exc = 1; e_cause = 13;
      end else if (!bus.is_eret) begin
        for (int i = 0; i < NI; i++) begin
          if (!found && m_pend[i] && bus.status[11 + i]) begin
            found = 1; e_exc = 1; e_ack = 1; e_id = i;
          end
        end
      end
    end
  endtask

  // One clock: model advances with the same inputs the DUT sees at the edge.
  task automatic tick();
    bit [NI-1:0] nxt;
    model_eval();
    nxt = m_pend & ~bus.irq_clr;
    if (e_ack) nxt[e_id] = 1'b0;
    // a line's rise reaches pending three edges after it was first sampled
    nxt = nxt | (m_hist[1] & ~m_hist[2]);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (e_exc) m_depth++;
      else if (bus.is_eret) begin
        if (m_depth == 0) m_err = 1'b1;
        else m_depth--;
      end
      m_pend    = nxt;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = bus.irq;
    end
    #1;
  endtask

  task automatic idle();
    bus.is_syscall = 0; bus.is_break = 0; bus.is_teq = 0;
    bus.teq_eq = 0; bus.is_eret = 0; bus.irq_clr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.pc = 32'h0; bus.status = 32'h0; bus.irq = '0;
    idle();
    model_reset();
    tick(); tick();
    checks++; if (bus.exception !== 1'b0) begin failures++; $display("FAIL reset_exception got=%0b exp=0", bus.exception); end
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", bus.flush); end
    checks++; if (bus.cause !== 5'd0) begin failures++; $display("FAIL reset_cause got=%0d exp=0", bus.cause); end
    checks++; if (bus.epc !== 32'd0) begin failures++; $display("FAIL reset_epc got=%h exp=0", bus.epc); end
    checks++; if (bus.irq_ack !== 1'b0) begin failures++; $display("FAIL reset_irq_ack got=%0b exp=0", bus.irq_ack); end
    checks++; if (bus.pending !== 4'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0000", bus.pending); end
    checks++; if (bus.depth !== 2'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", bus.depth); end
    checks++; if (bus.eret_err !== 1'b0) begin failures++; $display("FAIL reset_eret_err got=%0b exp=0", bus.eret_err); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_syscall();
    bus.status = 32'h0000_0701; bus.pc = 32'h0040_0020; bus.is_syscall = 1;
    #1;
    checks++; if (bus.exception !== 1'b1) begin failures++; $display("FAIL sys_exception got=%0b exp=1", bus.exception); end
    checks++; if (bus.cause !== 5'd8) begin failures++; $display("FAIL sys_cause got=%0d exp=8", bus.cause); end
    checks++; if (bus.epc !== 32'h0040_0020) begin failures++; $display("FAIL sys_epc got=%h exp=00400020", bus.epc); end
    checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL sys_flush got=%0b exp=1", bus.flush); end
    checks++; if (bus.irq_ack !== 1'b0) begin failures++; $display("FAIL sys_irq_ack got=%0b exp=0", bus.irq_ack); end
    tick();
    idle(); #1;
    checks++; if (bus.depth !== 2'd1) begin failures++; $display("FAIL sys_depth got=%0d exp=1", bus.depth); end
    bus.is_eret = 1; #1;
    checks++; if (bus.eret !== 1'b1) begin failures++; $display("FAIL sys_eret got=%0b exp=1", bus.eret); end
    tick();
    idle(); #1;
    checks++; if (bus.depth !== 2'd0) begin failures++; $display("FAIL sys_eret_depth got=%0d exp=0", bus.depth); end
  endtask

  task automatic test_disabled();
    bus.status = 32'h0000_0001; bus.is_syscall = 1; #1;
    checks++; if (bus.exception !== 1'b0) begin failures++; $display("FAIL dis_sys_exception got=%0b exp=0", bus.exception); end
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL dis_sys_flush got=%0b exp=0", bus.flush); end
    tick();
    idle(); bus.status = 32'h0000_0701; bus.is_teq = 1; bus.teq_eq = 0; #1;
    checks++; if (bus.exception !== 1'b0) begin failures++; $display("FAIL teq_ne_exception got=%0b exp=0", bus.exception); end
    bus.teq_eq = 1; #1;
    checks++; if (bus.cause !== 5'd13 || bus.exception !== 1'b1) begin failures++; $display("FAIL teq_eq_cause got=%0d/%0b exp=13/1", bus.cause, bus.exception); end
    tick();
    idle(); bus.is_eret = 1; tick(); idle(); #1;
    checks++; if (bus.depth !== 2'd0) begin failures++; $display("FAIL dis_depth got=%0d exp=0", bus.depth); end
  endtask

  task automatic test_irq_priority();
    bus.status = 32'h0000_7801; bus.irq = 4'b0110;
    tick();
    bus.irq = 4'b0000;
    tick();
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL irq_early_pending got=%b exp=0000", bus.pending); end
    tick();
    checks++; if (bus.pending !== 4'b0110) begin failures++; $display("FAIL irq_pending got=%b exp=0110", bus.pending); end
    checks++; if (bus.exception !== 1'b1 || bus.cause !== 5'd0) begin failures++; $display("FAIL irq_exc got=%0b/%0d exp=1/0", bus.exception, bus.cause); end
    checks++; if (bus.irq_ack !== 1'b1 || bus.irq_id !== 3'd1) begin failures++; $display("FAIL irq_ack_id got=%0b/%0d exp=1/1", bus.irq_ack, bus.irq_id); end
    tick();
    bus.status = 32'h0000_0000; #1;
    checks++; if (bus.pending !== 4'b0100) begin failures++; $display("FAIL irq_after_pending got=%b exp=0100", bus.pending); end
    checks++; if (bus.depth !== 2'd1) begin failures++; $display("FAIL irq_after_depth got=%0d exp=1", bus.depth); end
    checks++; if (bus.exception !== 1'b0) begin failures++; $display("FAIL irq_masked_exc got=%0b exp=0", bus.exception); end
    bus.status = 32'h0000_7801; bus.is_eret = 1; #1;
    checks++; if (bus.eret !== 1'b1 || bus.exception !== 1'b0) begin failures++; $display("FAIL eret_wins got=%0b/%0b exp=1/0", bus.eret, bus.exception); end
    tick();
    idle(); #1;
    checks++; if (bus.depth !== 2'd0) begin failures++; $display("FAIL eret_depth got=%0d exp=0", bus.depth); end
    checks++; if (bus.irq_ack !== 1'b1 || bus.irq_id !== 3'd2) begin failures++; $display("FAIL irq2_taken got=%0b/%0d exp=1/2", bus.irq_ack, bus.irq_id); end
    tick();
    checks++; if (bus.pending !== 4'b0000 || bus.depth !== 2'd1) begin failures++; $display("FAIL irq2_after got=%b/%0d exp=0000/1", bus.pending, bus.depth); end
    bus.is_eret = 1; tick(); idle();
  endtask

  task automatic test_eret_err();
    bus.status = 32'h0000_0701; bus.is_eret = 1; #1;
    checks++; if (bus.eret !== 1'b1) begin failures++; $display("FAIL err_eret_fwd got=%0b exp=1", bus.eret); end
    tick();
    idle(); #1;
    checks++; if (bus.eret_err !== 1'b1 || bus.depth !== 2'd0) begin failures++; $display("FAIL eret_err got=%0b/%0d exp=1/0", bus.eret_err, bus.depth); end
    for (int k = 1; k <= 3; k++) begin
      bus.is_syscall = 1; bus.pc = 32'h0040_0100 + 32'(4 * k); #1;
      checks++; if (bus.exception !== 1'b1) begin failures++; $display("FAIL nest_exc%0d got=%0b exp=1", k, bus.exception); end
      tick();
      checks++; if (bus.depth !== 2'(k)) begin failures++; $display("FAIL nest_depth%0d got=%0d exp=%0d", k, bus.depth, k); end
    end
    #1;
    checks++; if (bus.exception !== 1'b0 || bus.flush !== 1'b0) begin failures++; $display("FAIL nest_max_exc got=%0b/%0b exp=0/0", bus.exception, bus.flush); end
    tick();
    checks++; if (bus.depth !== 2'd3) begin failures++; $display("FAIL nest_sat got=%0d exp=3", bus.depth); end
    idle();
    for (int k = 0; k < 3; k++) begin bus.is_eret = 1; tick(); end
    idle(); #1;
    checks++; if (bus.depth !== 2'd0 || bus.eret_err !== 1'b1) begin failures++; $display("FAIL unwind got=%0d/%0b exp=0/1", bus.depth, bus.eret_err); end
  endtask

  task automatic test_reset_mid();
    bus.status = 32'h0000_0701; bus.is_syscall = 1;
    tick(); tick();
    idle(); bus.status = 32'h0000_0700; bus.irq = 4'b1000;
    tick(); tick(); tick();
    checks++; if (bus.pending !== 4'b1000 || bus.depth !== 2'd2) begin failures++; $display("FAIL mid_state got=%b/%0d exp=1000/2", bus.pending, bus.depth); end
    rst = 1'b0; model_reset(); #1;
    checks++; if (bus.depth !== 2'd0 || bus.pending !== 4'b0 || bus.eret_err !== 1'b0) begin failures++; $display("FAIL mid_async_rst got=%0d/%b/%0b exp=0/0000/0", bus.depth, bus.pending, bus.eret_err); end
    tick();
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL rel_early got=%b exp=0000", bus.pending); end
    tick();
    checks++; if (bus.pending !== 4'b1000) begin failures++; $display("FAIL rel_pending got=%b exp=1000", bus.pending); end
    bus.irq_clr = 4'b1000; tick(); bus.irq_clr = 4'b0000; tick();
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL irq_clr got=%b exp=0000", bus.pending); end
    bus.irq = 4'b0000; tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int r;
      idle();
      bus.pc     = $urandom & 32'hFFFF_FFFC;
      bus.status = ($urandom & 32'h0000_7F00) | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
      r = $urandom_range(0, 9);
      case (r)
        0: bus.is_syscall = 1;
        1: bus.is_break   = 1;
        2: begin bus.is_teq = 1; bus.teq_eq = 1'($urandom_range(0, 1)); end
        3, 4, 5: bus.is_eret = 1;
        default: ;
      endcase
      if ($urandom_range(0, 9) < 3) bus.irq[$urandom_range(0, NI - 1)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) bus.irq_clr[$urandom_range(0, NI - 1)] = 1'b1;
      #1;
      model_eval();
      checks++; if (bus.exception !== e_exc) begin failures++; $display("FAIL rnd_exc n=%0d got=%0b exp=%0b", n, bus.exception, e_exc); end
      checks++; if (bus.flush !== e_exc) begin failures++; $display("FAIL rnd_flush n=%0d got=%0b exp=%0b", n, bus.flush, e_exc); end
      checks++; if (bus.cause !== e_cause) begin failures++; $display("FAIL rnd_cause n=%0d got=%0d exp=%0d", n, bus.cause, e_cause); end
      checks++; if (bus.epc !== (e_exc ? bus.pc : 32'd0)) begin failures++; $display("FAIL rnd_epc n=%0d got=%h exp_taken=%0b", n, bus.epc, e_exc); end
      checks++; if (bus.irq_ack !== e_ack) begin failures++; $display("FAIL rnd_ack n=%0d got=%0b exp=%0b", n, bus.irq_ack, e_ack); end
      if (e_ack) begin
        checks++; if (bus.irq_id !== 3'(e_id)) begin failures++; $display("FAIL rnd_id n=%0d got=%0d exp=%0d", n, bus.irq_id, e_id); end
      end
      checks++; if (bus.eret !== bus.is_eret) begin failures++; $display("FAIL rnd_eret n=%0d got=%0b exp=%0b", n, bus.eret, bus.is_eret); end
      checks++; if (bus.pending !== m_pend) begin failures++; $display("FAIL rnd_pending n=%0d got=%b exp=%b", n, bus.pending, m_pend); end
      checks++; if (bus.depth !== 2'(m_depth)) begin failures++; $display("FAIL rnd_depth n=%0d got=%0d exp=%0d", n, bus.depth, m_depth); end
      checks++; if (bus.eret_err !== m_err) begin failures++; $display("FAIL rnd_eret_err n=%0d got=%0b exp=%0b", n, bus.eret_err, m_err); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_disabled();
    test_irq_priority();
    test_eret_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
